// File: rtl/legv8_pkg.sv
// ----------------------------------------------------------------------------
// legv8_pkg
// Shared constants for the LEGv8 datapath blocks.
//   LEGV8_CNT_W : default width of the taken-branch performance counter.
// ----------------------------------------------------------------------------
package legv8_pkg;

    localparam int unsigned LEGV8_CNT_W = 16;

endpackage : legv8_pkg

// File: rtl/cbnz_branch_and_gate_branch_cond.sv
// ----------------------------------------------------------------------------
// branch_cond
// Purely combinational branch-condition logic for the EX stage.
// Ports:
//   branch        in  CBNZ-type branch in EX
//   zero          in  ALU zero flag of the tested register
//   cbz_branch    in  CBZ-type branch in EX
//   uncond_branch in  unconditional B in EX
//   out           out CBNZ take condition (branch & ~zero)
//   pc_src        out PC-source select, OR of all take conditions
// ----------------------------------------------------------------------------
module branch_cond (
    input  logic branch,
    input  logic zero,
    input  logic cbz_branch,
    input  logic uncond_branch,
    output logic out,
    output logic pc_src
);

    logic cbnz_take_s;
    logic cbz_take_s;

    // Take conditions; a plain AND keeps out at 0 whenever zero is 1, even
    // if branch is unknown.
    always_comb begin
        cbnz_take_s = branch & ~zero;
        cbz_take_s  = cbz_branch & zero;
        out         = cbnz_take_s;
        pc_src      = cbnz_take_s | cbz_take_s | uncond_branch;
    end

endmodule : branch_cond

// File: rtl/cbnz_branch_and_gate.sv
// ----------------------------------------------------------------------------
// cbnz_branch_and_gate
// Branch-decision gate: combinational CBNZ condition and PC-source select,
// an EX/MEM registered copy of the select, and a saturating counter of
// registered taken decisions.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   branch, zero   CBNZ inputs          -> out (comb)
//   cbz_branch     CBZ instruction in EX
//   uncond_branch  B instruction in EX
//   stall          hold registered state
//   flush          clear registered decision (wins over stall)
//   pc_src         comb PC-source select
//   pc_src_q       registered pc_src
//   taken_cnt      saturating count of registered taken decisions
// ----------------------------------------------------------------------------
module cbnz_branch_and_gate
    import legv8_pkg::*;
#(
    parameter int unsigned CNT_W = LEGV8_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch,
    input  logic             zero,
    output logic             out,
    input  logic             cbz_branch,
    input  logic             uncond_branch,
    input  logic             stall,
    input  logic             flush,
    output logic             pc_src,
    output logic             pc_src_q,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             pc_src_d;
    logic [CNT_W-1:0] taken_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q;

    branch_cond u_branch_cond (
        .branch        (branch),
        .zero          (zero),
        .cbz_branch    (cbz_branch),
        .uncond_branch (uncond_branch),
        .out           (out),
        .pc_src        (pc_src)
    );

    // Next-state for the EX/MEM decision and counter: flush > stall > load.
    always_comb begin
        pc_src_d    = pc_src_q;
        taken_cnt_d = taken_cnt_q;
        if (flush) begin
            pc_src_d    = 1'b0;
        end else if (stall) begin
            pc_src_d    = pc_src_q;
            taken_cnt_d = taken_cnt_q;
        end else begin
            pc_src_d = pc_src;
            // Counter sticks at all-ones rather than wrapping.
            if (pc_src && (taken_cnt_q != CNT_MAX)) begin
                taken_cnt_d = taken_cnt_q + CNT_ONE;
            end else begin
                taken_cnt_d = taken_cnt_q;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_src_q    <= 1'b0;
            taken_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pc_src_q    <= pc_src_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;

endmodule : cbnz_branch_and_gate

// File: tb/tb_cbnz_branch_and_gate.sv
// ----------------------------------------------------------------------------
// tb_cbnz_branch_and_gate
// Directed bench: one default-width instance and one CNT_W=2 instance share
// the same stimulus; expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_cbnz_branch_and_gate;

    logic        clk;
    logic        rst;
    logic        branch;
    logic        zero;
    logic        cbz_branch;
    logic        uncond_branch;
    logic        stall;
    logic        flush;

    logic        out_w;
    logic        pc_src_w;
    logic        pc_src_q_w;
    logic [15:0] cnt_w;

    logic        out_n;
    logic        pc_src_n;
    logic        pc_src_q_n;
    logic [1:0]  cnt_n;

    int errors = 0;
    int checks = 0;

    cbnz_branch_and_gate u_dut (
        .clk           (clk),
        .rst           (rst),
        .branch        (branch),
        .zero          (zero),
        .out           (out_w),
        .cbz_branch    (cbz_branch),
        .uncond_branch (uncond_branch),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src_w),
        .pc_src_q      (pc_src_q_w),
        .taken_cnt     (cnt_w)
    );

    cbnz_branch_and_gate #(.CNT_W(2)) u_dut_small (
        .clk           (clk),
        .rst           (rst),
        .branch        (branch),
        .zero          (zero),
        .out           (out_n),
        .cbz_branch    (cbz_branch),
        .uncond_branch (uncond_branch),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src_n),
        .pc_src_q      (pc_src_q_n),
        .taken_cnt     (cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; branch = 1'b0; zero = 1'b0; cbz_branch = 1'b0;
        uncond_branch = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        check("rst_pc_src_q", {31'd0, pc_src_q_w}, 32'd0);
        check("rst_cnt", {16'd0, cnt_w}, 32'd0);
        check("rst_cnt_small", {30'd0, cnt_n}, 32'd0);

        // Combinational sweep under reset: outputs follow inputs.
        branch = 1'b1; zero = 1'b1; #1;
        check("sweep11_out", {31'd0, out_w}, 32'd0);
        check("sweep11_pc", {31'd0, pc_src_w}, 32'd0);
        #4; branch = 1'b0; zero = 1'b1; #1;
        check("sweep01_out", {31'd0, out_w}, 32'd0);
        check("sweep01_pc", {31'd0, pc_src_w}, 32'd0);
        #4; branch = 1'b0; zero = 1'b0; #1;
        check("sweep00_out", {31'd0, out_w}, 32'd0);
        check("sweep00_pc", {31'd0, pc_src_w}, 32'd0);
        #4; branch = 1'b1; zero = 1'b0; #1;
        check("sweep10_out", {31'd0, out_w}, 32'd1);
        check("sweep10_pc", {31'd0, pc_src_w}, 32'd1);
        #4; branch = 1'b1; zero = 1'b1; #1;
        check("sweep11b_out", {31'd0, out_w}, 32'd0);
        check("sweep11b_pc", {31'd0, pc_src_w}, 32'd0);
        #4; branch = 1'bx; zero = 1'b1; #1;
        check("x_branch_out", {31'd0, out_w}, 32'd0);
        #4; branch = 1'b0; cbz_branch = 1'b1; zero = 1'b1; #1;
        check("cbz_pc", {31'd0, pc_src_w}, 32'd1);
        check("cbz_out", {31'd0, out_w}, 32'd0);
        #4; cbz_branch = 1'b0; zero = 1'b0; uncond_branch = 1'b1; #1;
        check("uncond_pc", {31'd0, pc_src_w}, 32'd1);
        check("uncond_out", {31'd0, out_w}, 32'd0);
        check("rst_hold_q", {31'd0, pc_src_q_w}, 32'd0);
        check("rst_hold_cnt", {16'd0, cnt_w}, 32'd0);

        // Release reset away from the rising edge with all inputs idle.
        uncond_branch = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // CBNZ taken for three clocks.
        branch = 1'b1; zero = 1'b0;
        tick();
        check("take1_q", {31'd0, pc_src_q_w}, 32'd1);
        check("take1_cnt", {16'd0, cnt_w}, 32'd1);
        tick();
        tick();
        check("take3_cnt", {16'd0, cnt_w}, 32'd3);
        check("take3_cnt_small", {30'd0, cnt_n}, 32'd3);

        // Stall holds both registers, even when pc_src drops.
        stall = 1'b1;
        tick();
        check("stall_q", {31'd0, pc_src_q_w}, 32'd1);
        check("stall_cnt", {16'd0, cnt_w}, 32'd3);
        branch = 1'b0;
        tick();
        check("stall_hold_q", {31'd0, pc_src_q_w}, 32'd1);

        // Flush beats stall; counter untouched.
        branch = 1'b1; flush = 1'b1;
        tick();
        check("flush_q", {31'd0, pc_src_q_w}, 32'd0);
        check("flush_cnt", {16'd0, cnt_w}, 32'd3);

        // Two more taken cycles: small counter saturates at 3.
        stall = 1'b0; flush = 1'b0;
        tick();
        tick();
        check("take5_q", {31'd0, pc_src_q_w}, 32'd1);
        check("take5_cnt", {16'd0, cnt_w}, 32'd5);
        check("sat_cnt_small", {30'd0, cnt_n}, 32'd3);

        // CBZ taken is registered and counted too.
        branch = 1'b0; cbz_branch = 1'b1; zero = 1'b1;
        tick();
        check("cbz_q", {31'd0, pc_src_q_w}, 32'd1);
        check("cbz_cnt", {16'd0, cnt_w}, 32'd6);
        check("cbz_cnt_small", {30'd0, cnt_n}, 32'd3);

        // Not-taken cycle.
        cbz_branch = 1'b0;
        tick();
        check("idle_q", {31'd0, pc_src_q_w}, 32'd0);
        check("idle_cnt", {16'd0, cnt_w}, 32'd6);

        // Taken again, then asynchronous reset mid-cycle.
        branch = 1'b1; zero = 1'b0;
        tick();
        check("pre_rst_q", {31'd0, pc_src_q_w}, 32'd1);
        check("pre_rst_cnt", {16'd0, cnt_w}, 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q", {31'd0, pc_src_q_w}, 32'd0);
        check("async_rst_cnt", {16'd0, cnt_w}, 32'd0);
        check("async_rst_cnt_small", {30'd0, cnt_n}, 32'd0);
        check("rst_out_tracks1", {31'd0, out_w}, 32'd1);
        zero = 1'b1;
        #1;
        check("rst_out_tracks0", {31'd0, out_w}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cbnz_branch_and_gate

// File: doc/cbnz_branch_and_gate.md
# cbnz_branch_and_gate

Branch-decision gate for the LEGv8 datapath. Asserts the CBNZ take-branch condition (`branch` AND NOT `zero`), merges it with the CBZ and unconditional-branch conditions into a PC-source select, and registers the decision into the EX/MEM boundary. A saturating taken-branch counter is provided for performance monitoring.

## Interface
- `CNT_W`, default 16: width of the taken-branch counter.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `branch`  in  1  CBNZ-type branch instruction in EX.
- `zero`  in  1  ALU zero flag for the tested register.
- `out`  out  1  CBNZ take condition, combinational: `branch & ~zero`.
- `cbz_branch`  in  1  CBZ-type branch instruction in EX.
- `uncond_branch`  in  1  unconditional B instruction in EX.
- `stall`  in  1  hold registered state.
- `flush`  in  1  clear registered decision (bubble).
- `pc_src`  out  1  combinational PC-source select: `out | (cbz_branch & zero) | uncond_branch`.
- `pc_src_q`  out  1  registered `pc_src` (EX/MEM copy).
- `taken_cnt`  out  CNT_W  saturating count of cycles where a taken decision was registered.

## Operation
- `out` depends only on `branch` and `zero`; no clock or reset involvement. Truth table: (1,1)->0, (0,1)->0, (0,0)->0, (1,0)->1.
- `pc_src` is purely combinational over the four decision inputs; it never depends on `stall`, `flush` or `rst`.
- Registered path, priority order per rising edge:
  1. `rst` high (asynchronous): `pc_src_q`=0, `taken_cnt`=0.
  2. `flush` high: `pc_src_q`<=0; counter unchanged. Flush wins over stall.
  3. `stall` high: `pc_src_q` and `taken_cnt` hold.
  4. Otherwise: `pc_src_q`<=`pc_src`; if `pc_src`=1, `taken_cnt`<=`taken_cnt`+1, saturating at all-ones (no wrap).
- Multiple branch inputs high at once are legal; result is the OR of their conditions.
- X on `branch` with `zero`=1 must still yield `out`=0 (AND-gate semantics); no other X-handling required.

## Timing
- `out`, `pc_src`: zero-cycle latency, combinational.
- `pc_src_q`: one-cycle latency from inputs; valid the cycle after sampling.
- Reset value of every registered output is 0; combinational outputs follow inputs during reset.
- Reset asserted mid-operation clears registers immediately, without waiting for a clock edge; release is synchronized externally.
- Counter at 2^CNT_W-1 stays there on further taken decisions.

## Structure
- Shared package `legv8_pkg`: `CNT_W` default constant.
- One sub-module natural: `branch_cond` (combinational `out`/`pc_src` logic), instantiated by the top, which holds the registers and counter.
- No state machine.

## Test plan
- Combinational sweep of (`branch`,`zero`) = (1,1),(0,1),(0,0),(1,0),(1,1) at 5-time-unit spacing -> `out` = 0,0,0,1,0; `pc_src` equals `out` while the other branch inputs are 0.
- `cbz_branch`=1, `zero`=1, `branch`=0 -> `pc_src`=1, `out`=0; `uncond_branch`=1 alone -> `pc_src`=1.
- `branch`=1, `zero`=0 for 3 clocks -> `pc_src_q`=1 one cycle after the first edge; `taken_cnt`=3.
- Stall asserted with a taken condition -> `pc_src_q` and `taken_cnt` unchanged; flush together with stall -> `pc_src_q`=0.
- `CNT_W`=2, 5 taken cycles -> `taken_cnt` saturates at 3.
- Assert `rst` between clock edges with `pc_src_q`=1 -> `pc_src_q`=0 and `taken_cnt`=0 immediately; `out` keeps tracking inputs.
